// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte input, 8N1 or 8-parity-1 frames at a runtime clock divider.
// Define UART_TX_FIFO_EN to place a 4-entry FIFO between the handshake and the shifter.
module uart_tx #(
    parameter int CLOCK_DIVIDER_WIDTH = 16
) (
    input  logic                           clock_i,
    input  logic                           reset_ni,
    input  logic [CLOCK_DIVIDER_WIDTH-1:0] clock_divider_i,
    input  logic                           parity_bit_i,
    input  logic                           parity_even_i,
    input  logic [7:0]                     data_i,
    input  logic                           send_i,
    output logic                           ready_o,
    output logic                           busy_o,
    output logic                           serial_o
);
    localparam logic [CLOCK_DIVIDER_WIDTH-1:0] DIV_ONE = CLOCK_DIVIDER_WIDTH'(1);
    localparam logic [CLOCK_DIVIDER_WIDTH-1:0] DIV_TWO = CLOCK_DIVIDER_WIDTH'(2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                         state_reg;
    logic [CLOCK_DIVIDER_WIDTH-1:0] timer_reg;
    logic [CLOCK_DIVIDER_WIDTH-1:0] divider_reg;
    logic [2:0]                     bit_idx_reg;
    logic [7:0]                     shift_data_reg;
    logic                           parity_en_reg;
    logic                           parity_even_reg;
    logic                           serial_reg;

    logic       pending;
    logic [7:0] head_data;
    logic       push;
    logic       pop;
    logic       divider_ok;
    logic       bit_done;

    assign divider_ok = (clock_divider_i >= DIV_TWO);
    assign bit_done   = (timer_reg == '0);
    // A frame starts from IDLE, or straight out of the last stop-bit clock for gapless streaming.
    assign pop  = pending && divider_ok &&
                  ((state_reg == IDLE) || ((state_reg == STOP) && bit_done));
    assign push = send_i && ready_o;

`ifdef UART_TX_FIFO_EN
    logic [7:0] fifo_mem [4];
    logic [1:0] wr_ptr_reg;
    logic [1:0] rd_ptr_reg;
    logic [2:0] count_reg;

    always_ff @(posedge clock_i) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= data_i;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 2'd1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 2'd1;
            end
            count_reg <= count_reg + 3'(push) - 3'(pop);
        end
    end

    // The shifter's data register captures the head entry on pop, acting as the read register.
    assign head_data = fifo_mem[rd_ptr_reg];
    assign pending   = (count_reg != 3'd0);
    assign ready_o   = (count_reg != 3'd4);
`else
    logic       pending_reg;
    logic [7:0] pending_data_reg;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pending_reg      <= 1'b0;
            pending_data_reg <= '0;
        end else if (push) begin
            pending_reg      <= 1'b1;
            pending_data_reg <= data_i;
        end else if (pop) begin
            pending_reg <= 1'b0;
        end
    end

    assign head_data = pending_data_reg;
    assign pending   = pending_reg;
    assign ready_o   = (state_reg == IDLE) && !pending_reg;
`endif

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_reg       <= IDLE;
            timer_reg       <= '0;
            divider_reg     <= '0;
            bit_idx_reg     <= '0;
            shift_data_reg  <= '0;
            parity_en_reg   <= 1'b0;
            parity_even_reg <= 1'b0;
            serial_reg      <= 1'b1;
        end else if (pop) begin
            state_reg       <= START;
            shift_data_reg  <= head_data;
            divider_reg     <= clock_divider_i;
            parity_en_reg   <= parity_bit_i;
            parity_even_reg <= parity_even_i;
            timer_reg       <= clock_divider_i - DIV_ONE;
            bit_idx_reg     <= '0;
            serial_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    serial_reg <= 1'b1;
                end
                START: begin
                    if (bit_done) begin
                        state_reg   <= DATA;
                        timer_reg   <= divider_reg - DIV_ONE;
                        bit_idx_reg <= '0;
                        serial_reg  <= shift_data_reg[0];
                    end else begin
                        timer_reg <= timer_reg - DIV_ONE;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        timer_reg <= divider_reg - DIV_ONE;
                        if (bit_idx_reg == 3'd7) begin
                            if (parity_en_reg) begin
                                state_reg  <= PARITY;
                                serial_reg <= parity_even_reg ? ^shift_data_reg : ~^shift_data_reg;
                            end else begin
                                state_reg  <= STOP;
                                serial_reg <= 1'b1;
                            end
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                            serial_reg  <= shift_data_reg[bit_idx_reg + 3'd1];
                        end
                    end else begin
                        timer_reg <= timer_reg - DIV_ONE;
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        state_reg  <= STOP;
                        timer_reg  <= divider_reg - DIV_ONE;
                        serial_reg <= 1'b1;
                    end else begin
                        timer_reg <= timer_reg - DIV_ONE;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        state_reg  <= IDLE;
                        serial_reg <= 1'b1;
                    end else begin
                        timer_reg <= timer_reg - DIV_ONE;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    serial_reg <= 1'b1;
                end
            endcase
        end
    end

    assign busy_o   = (state_reg != IDLE);
    assign serial_o = serial_reg;
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: reset/idle, frame shape and timing, parity, reset abort,
// divider gating, and (when UART_TX_FIFO_EN is defined) gapless FIFO streaming.
module tb_uart_tx;
    logic        clk;
    logic        rst_n;
    logic [15:0] divider;
    logic        parity_bit;
    logic        parity_even;
    logic [7:0]  data;
    logic        send;
    logic        ready;
    logic        busy;
    logic        serial;

    int tests = 0;
    int fails = 0;

    uart_tx #(.CLOCK_DIVIDER_WIDTH(16)) dut (
        .clock_i        (clk),
        .reset_ni       (rst_n),
        .clock_divider_i(divider),
        .parity_bit_i   (parity_bit),
        .parity_even_i  (parity_even),
        .data_i         (data),
        .send_i         (send),
        .ready_o        (ready),
        .busy_o         (busy),
        .serial_o       (serial)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("[TB] check %s observed %0h expected %0h", tag, obs, exp);
    endtask

    // Present a byte and hold send until the DUT accepts it; returns at the negedge after acceptance.
    task automatic send_byte(input string tag, input logic [7:0] d);
        int n;
        @(negedge clk);
        data = d;
        send = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_accept"}, ready, 1'b1);
        @(negedge clk);
        send = 1'b0;
    endtask

    task automatic idle_check(input string tag, input int n, input bit want_ready);
        int err;
        err = 0;
        for (int i = 0; i < n; i++) begin
            if (serial !== 1'b1 || busy !== 1'b0) err++;
            if (want_ready && ready !== 1'b1) err++;
            @(negedge clk);
        end
        check({tag, "_idle_errs"}, err, 0);
    endtask

    // Waits for a start bit, then checks every clock of the frame against the expected bit
    // and that busy stays high; decodes the byte from mid-bit samples like a receiver would.
    task automatic check_frame(input string tag, input logic [7:0] d, input bit pe, input bit pev,
                               input int dv, output int waited, output logic par);
        int err;
        int nbits;
        logic eb;
        logic [7:0] dec;
        err = 0;
        dec = 8'h00;
        par = 1'bx;
        waited = 0;
        while (serial !== 1'b0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_start"}, serial, 1'b0);
        nbits = pe ? 11 : 10;
        for (int b = 0; b < nbits; b++) begin
            if (b == 0) eb = 1'b0;
            else if (b <= 8) eb = d[b-1];
            else if (pe && b == 9) eb = pev ? ^d : ~^d;
            else eb = 1'b1;
            for (int k = 0; k < dv; k++) begin
                if (serial !== eb) err++;
                if (busy !== 1'b1) err++;
                if (k == dv / 2) begin
                    if (b >= 1 && b <= 8) dec[b-1] = serial;
                    if (pe && b == 9) par = serial;
                end
                @(negedge clk);
            end
        end
        check({tag, "_bit_errs"}, err, 0);
        check({tag, "_data"}, dec, d);
    endtask

    int waited;
    logic par;

    initial begin
        logic [7:0] vals [5];
        logic exp_bits [200];
        logic samples [$];
        int err;
        int first;
        int eidx;

        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44; vals[4] = 8'h55;
        rst_n = 1'b0;
        divider = 16'd4;
        parity_bit = 1'b0;
        parity_even = 1'b0;
        data = 8'h00;
        send = 1'b0;

        // Reset state, then 50 idle clocks
        #12;
        check("rst_serial", serial, 1'b1);
        check("rst_ready", ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_check("idle50", 50, 1'b1);

        // 0xA5, D=4, no parity: line still idle one clock after accept, start the next clock
        send_byte("a5", 8'hA5);
        check("a5_pre_serial", serial, 1'b1);
        check("a5_pre_busy", busy, 1'b0);
        check_frame("a5", 8'hA5, 1'b0, 1'b0, 4, waited, par);
        check("a5_latency", waited, 1);
        check("a5_busy_after", busy, 1'b0);

        // 0x07 with even then odd parity, D=8
        divider = 16'd8;
        parity_bit = 1'b1;
        parity_even = 1'b1;
        send_byte("p_even", 8'h07);
        check_frame("p_even", 8'h07, 1'b1, 1'b1, 8, waited, par);
        check("p_even_par", par, 1'b1);
        check("p_even_busy_after", busy, 1'b0);
        parity_even = 1'b0;
        send_byte("p_odd", 8'h07);
`ifndef UART_TX_FIFO_EN
        // A send while not ready must be dropped
        check("busy_not_ready", ready, 1'b0);
        data = 8'hEE;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
`endif
        check_frame("p_odd", 8'h07, 1'b1, 1'b0, 8, waited, par);
        check("p_odd_par", par, 1'b0);
        idle_check("p_odd_after", 20, 1'b1);
        parity_bit = 1'b0;

        // Asynchronous reset in the middle of the data bits of 0xFF
        divider = 16'd4;
        send_byte("ff", 8'hFF);
        repeat (12) @(negedge clk);
        check("ff_midframe_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ff_async_serial", serial, 1'b1);
        check("ff_async_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_check("ff_after_rst", 20, 1'b1);
        send_byte("c3", 8'hC3);
        check_frame("c3", 8'hC3, 1'b0, 1'b0, 4, waited, par);
        check("c3_busy_after", busy, 1'b0);

        // Divider below 2 holds the byte until the divider becomes valid
        divider = 16'd1;
        send_byte("div1", 8'h5A);
        idle_check("div1_hold", 20, 1'b0);
`ifndef UART_TX_FIFO_EN
        check("div1_ready_low", ready, 1'b0);
`endif
        divider = 16'd3;
        check_frame("div3", 8'h5A, 1'b0, 1'b0, 3, waited, par);
        check("div3_latency", waited, 1);
        check("div3_busy_after", busy, 1'b0);

`ifdef UART_TX_FIFO_EN
        // Five pushes on consecutive clocks at D=2; frames must stream back-to-back
        divider = 16'd2;
        err = 0;
        samples.delete();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ready !== 1'b1) err++;
            samples.push_back(serial);
            data = vals[i];
            send = 1'b1;
        end
        check("fifo_ready_during_push", err, 0);
        @(negedge clk);
        send = 1'b0;
        check("fifo_full_after5", ready, 1'b0);
        samples.push_back(serial);
        for (int i = 0; i < 110; i++) begin
            @(negedge clk);
            samples.push_back(serial);
        end
        eidx = 0;
        for (int f = 0; f < 5; f++) begin
            for (int b = 0; b < 10; b++) begin
                for (int k = 0; k < 2; k++) begin
                    if (b == 0) exp_bits[eidx] = 1'b0;
                    else if (b <= 8) exp_bits[eidx] = vals[f][b-1];
                    else exp_bits[eidx] = 1'b1;
                    eidx++;
                end
            end
        end
        first = -1;
        for (int i = 0; i < samples.size(); i++) begin
            if (first < 0 && samples[i] === 1'b0) first = i;
        end
        check("fifo_first_start", first, 2);
        err = 0;
        for (int i = 0; i < 100; i++) begin
            if (samples[first + i] !== exp_bits[i]) err++;
        end
        check("fifo_stream_errs", err, 0);
        check("fifo_line_after", samples[first + 100], 1'b1);
        check("fifo_busy_end", busy, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
